qspi_sram_responder: RTL

QSPI_SRAM_RESPONDER -- requirements
Module: qspi_sram_responder

---
 rtl/qspi_sram_responder_pkg.sv | 23 ++
 rtl/qspi_sram_responder_if.sv | 24 ++
 rtl/qspi_sram_responder_sync_edge.sv | 28 ++
 rtl/qspi_sram_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_responder_pkg.sv
// Shared constants and types for the QSPI SRAM responder: opcodes,
// phase lengths and the FSM state encoding.
package qspi_sram_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_e;

    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_EQIO   = 8'h38;
    localparam logic [7:0] OP_RSTQIO = 8'hFF;

    localparam int ADDR_NIBBLES  = 6;
    localparam int DUMMY_NIBBLES = 2;

endpackage

// File: rtl/qspi_sram_responder_if.sv
// Serial SRAM bus between an initiator (master) and the responder (slave).
interface qspi_sram_responder_if;
    logic       sram_cs_n;
    logic       sram_sck;
    logic [3:0] sram_sio_i;
    logic [3:0] sram_sio_o;
    logic       sram_sio_oe;

    modport master (
        output sram_cs_n,
        output sram_sck,
        output sram_sio_i,
        input  sram_sio_o,
        input  sram_sio_oe
    );

    modport slave (
        input  sram_cs_n,
        input  sram_sck,
        input  sram_sio_i,
        output sram_sio_o,
        output sram_sio_oe
    );
endinterface

// File: rtl/qspi_sram_responder_sync_edge.sv
// Two-flop synchronizer with a third history flop for rise/fall detection
// on the synchronized value. IDLE_VAL is the level loaded during reset.
module sync_edge_detect #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_reg <= {3{IDLE_VAL}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], async_in};
        end
    end

    assign sync_out = pipe_reg[1];
    assign rise     = pipe_reg[1] & ~pipe_reg[2];
    assign fall     = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/qspi_sram_responder.sv
// SPI/SQI serial SRAM model: oversamples the initiator's bus with clk,
// supports EQIO/RSTQIO mode switching and quad sequential read/write.
module qspi_sram_responder
    import qspi_sram_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter bit RESET_QUAD     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qspi_sram_responder_if.slave  sram,
    output logic                  quad_mode
);

    logic       cs_sync, cs_rise, cs_fall;
    logic       sck_sync, sck_rise, sck_fall;
    logic [3:0] sio_sync;

    sync_edge_detect #(.IDLE_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (sram.sram_cs_n),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    sync_edge_detect #(.IDLE_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (sram.sram_sck),
        .sync_out (sck_sync),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // Same two-stage latency as SCK so data is aligned with the detected rise.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sio_sync
            logic meta_reg;
            logic stage_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    meta_reg  <= 1'b0;
                    stage_reg <= 1'b0;
                end else begin
                    meta_reg  <= sram.sram_sio_i[gi];
                    stage_reg <= meta_reg;
                end
            end
            assign sio_sync[gi] = stage_reg;
        end
    endgenerate

    state_e                    state_reg, state_next;
    logic [2:0]                cnt_reg, cnt_next;
    logic [7:0]                cmd_reg, cmd_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [3:0]                hi_reg, hi_next;
    logic                      phase_reg, phase_next;
    logic                      is_write_reg, is_write_next;
    logic [3:0]                sio_o_reg, sio_o_next;
    logic                      oe_reg, oe_next;
    logic                      quad_reg, quad_next;
    logic                      pend_set_reg, pend_set_next;
    logic                      pend_clr_reg, pend_clr_next;
    logic [1:0]                settle_reg, settle_next;
    logic                      armed_reg, armed_next;

    logic [7:0]                mem [0:(2**MEM_ADDR_WIDTH)-1];
    logic [7:0]                rd_data_reg;
    logic                      mem_we;
    logic [7:0]                mem_wdata;

    logic [7:0]                cmd_spi, cmd_quad;
    logic [MEM_ADDR_WIDTH+3:0] addr_shift;
    logic [MEM_ADDR_WIDTH-1:0] addr_inc;

    assign cmd_spi    = {cmd_reg[6:0], sio_sync[0]};
    assign cmd_quad   = {cmd_reg[3:0], sio_sync};
    assign addr_shift = {addr_reg, sio_sync};
    assign addr_inc   = addr_reg + MEM_ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            hi_reg       <= '0;
            phase_reg    <= 1'b0;
            is_write_reg <= 1'b0;
            sio_o_reg    <= 4'b0000;
            oe_reg       <= 1'b0;
            quad_reg     <= RESET_QUAD;
            pend_set_reg <= 1'b0;
            pend_clr_reg <= 1'b0;
            settle_reg   <= '0;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cmd_reg      <= cmd_next;
            addr_reg     <= addr_next;
            hi_reg       <= hi_next;
            phase_reg    <= phase_next;
            is_write_reg <= is_write_next;
            sio_o_reg    <= sio_o_next;
            oe_reg       <= oe_next;
            quad_reg     <= quad_next;
            pend_set_reg <= pend_set_next;
            pend_clr_reg <= pend_clr_next;
            settle_reg   <= settle_next;
            armed_reg    <= armed_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cmd_next      = cmd_reg;
        addr_next     = addr_reg;
        hi_next       = hi_reg;
        phase_next    = phase_reg;
        is_write_next = is_write_reg;
        sio_o_next    = sio_o_reg;
        oe_next       = (state_reg == READ) ? oe_reg : 1'b0;
        quad_next     = quad_reg;
        pend_set_next = pend_set_reg;
        pend_clr_next = pend_clr_reg;
        mem_we        = 1'b0;
        mem_wdata     = {hi_reg, sio_sync};

        // The synchronizer holds its reset level for a few clocks, so a CS
        // fall is only trusted once CS has genuinely been seen high.
        settle_next = (settle_reg == 2'd3) ? settle_reg : settle_reg + 2'd1;
        armed_next  = armed_reg | ((settle_reg == 2'd3) & cs_sync);

        if (cs_sync) begin
            state_next    = IDLE;
            cnt_next      = '0;
            phase_next    = 1'b0;
            oe_next       = 1'b0;
            pend_set_next = 1'b0;
            pend_clr_next = 1'b0;
            if (cs_rise && pend_set_reg) begin
                quad_next = 1'b1;
            end else if (cs_rise && pend_clr_reg) begin
                quad_next = 1'b0;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (cs_fall && armed_reg && !sck_sync) begin
                        state_next = CMD;
                        cnt_next   = '0;
                        cmd_next   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise && !quad_reg) begin
                        cmd_next = cmd_spi;
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            state_next    = IGNORE;
                            pend_set_next = (cmd_spi == OP_EQIO);
                        end
                    end else if (sck_rise) begin
                        cmd_next = cmd_quad;
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == 3'd1) begin
                            cnt_next = '0;
                            case (cmd_quad)
                                OP_READ: begin
                                    state_next    = ADDR;
                                    is_write_next = 1'b0;
                                end
                                OP_WRITE: begin
                                    state_next    = ADDR;
                                    is_write_next = 1'b1;
                                end
                                OP_RSTQIO: begin
                                    state_next    = IGNORE;
                                    pend_clr_next = 1'b1;
                                end
                                default: state_next = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_next = addr_shift[MEM_ADDR_WIDTH-1:0];
                        cnt_next  = cnt_reg + 3'd1;
                        if (cnt_reg == 3'(ADDR_NIBBLES - 1)) begin
                            cnt_next   = '0;
                            phase_next = 1'b0;
                            state_next = is_write_reg ? WRITE : DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg == 3'(DUMMY_NIBBLES - 1)) begin
                            cnt_next   = '0;
                            phase_next = 1'b0;
                            state_next = READ;
                        end
                    end
                end
                READ: begin
                    // rd_data_reg tracks addr_reg; it has settled long before the next fall.
                    if (sck_fall) begin
                        oe_next    = 1'b1;
                        sio_o_next = phase_reg ? rd_data_reg[3:0] : rd_data_reg[7:4];
                        phase_next = ~phase_reg;
                        if (phase_reg) begin
                            addr_next = addr_inc;
                        end
                    end
                end
                WRITE: begin
                    if (sck_rise && !phase_reg) begin
                        hi_next    = sio_sync;
                        phase_next = 1'b1;
                    end else if (sck_rise) begin
                        mem_we     = 1'b1;
                        addr_next  = addr_inc;
                        phase_next = 1'b0;
                    end
                end
                IGNORE: ;
                default: state_next = IDLE;
            endcase
        end
    end

    // Array storage is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= mem_wdata;
        end
        rd_data_reg <= mem[addr_reg];
    end

    assign sram.sram_sio_o  = sio_o_reg;
    assign sram.sram_sio_oe = oe_reg;
    assign quad_mode        = quad_reg;

endmodule
